// File: rtl/fixed_point_pkg.sv
// Shared fixed-point definitions for the regressor datapath (dot-product and
// add/sub stages): word format, saturation limits, rounding constant, and a
// saturating narrow-to-WIDTH helper.
package fixed_point_pkg;

  localparam int WIDTH     = 32;
  localparam int FRAC_BITS = 16;
  localparam int WIDE      = 2 * WIDTH;

  localparam logic signed [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  // Half an LSB of the output format, added before the arithmetic shift.
  localparam logic signed [WIDE-1:0] ROUND_CONST = WIDE'(1) << (FRAC_BITS - 1);

  typedef struct packed {
    logic signed [WIDTH-1:0] value;
    logic                    ovf;
  } sat_t;

  typedef enum logic [1:0] {
    ST_ACCUM,
    ST_DRAIN,
    ST_HOLD
  } state_t;

  // Clamp a sign-extended wide value into the WIDTH-bit range, flagging a clamp.
  function automatic sat_t saturate(input logic signed [WIDE-1:0] v);
    sat_t                   res;
    logic signed [WIDE-1:0] wide_max;
    logic signed [WIDE-1:0] wide_min;
    wide_max = {{WIDTH{1'b0}}, SAT_MAX};
    wide_min = {{WIDTH{1'b1}}, SAT_MIN};
    res.ovf  = 1'b1;
    if (v > wide_max) begin
      res.value = SAT_MAX;
    end else if (v < wide_min) begin
      res.value = SAT_MIN;
    end else begin
      res.value = v[WIDTH-1:0];
      res.ovf   = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/fixed_point_mul.sv
// Two-stage fixed-point multiplier: stage 1 registers the full-width signed
// product, stage 2 rounds half-up, saturates to WIDTH bits and reports a clamp.
module fixed_point_mul
  import fixed_point_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] in_a,
  input  logic signed [WIDTH-1:0] in_b,
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] out_r,
  output logic                    out_overflow
);

  logic signed [WIDE-1:0] a_ext;
  logic signed [WIDE-1:0] b_ext;
  logic signed [WIDE-1:0] prod;
  logic                   prod_valid;
  logic signed [WIDE-1:0] rounded;
  sat_t                   sat_r;

  assign a_ext = {{WIDTH{in_a[WIDTH-1]}}, in_a};
  assign b_ext = {{WIDTH{in_b[WIDTH-1]}}, in_b};

  // Stage 1 valid bit: cleared by reset so no stale product survives it.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    if (rst) prod_valid <= 1'b0;
    else     prod_valid <= in_valid;
  end

  // Stage 1 data: full-width signed product.
  always_ff @(posedge clk) begin
    // NOTE: data registers are not reset; the accompanying valid bit decides
    // whether their contents mean anything.
    prod <= a_ext * b_ext;
  end

  assign rounded = (prod + ROUND_CONST) >>> FRAC_BITS;
  assign sat_r   = saturate(rounded);

  // Stage 2 valid bit.
  always_ff @(posedge clk) begin
    if (rst) out_valid <= 1'b0;
    else     out_valid <= prod_valid;
  end

  // Stage 2 data: rounded, saturated product and its clamp flag.
  always_ff @(posedge clk) begin
    out_r        <= sat_r.value;
    out_overflow <= sat_r.ovf;
  end

endmodule

// File: rtl/fixed_point_dot_accum.sv
// Streaming dot-product unit: y_hat = bias + sum(round(x_i * w_i)), with
// saturating accumulation and a sticky per-vector overflow flag.
module fixed_point_dot_accum
  import fixed_point_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_x,
  input  logic signed [WIDTH-1:0] in_w,
  input  logic                    in_last,
  input  logic signed [WIDTH-1:0] bias,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_y,
  output logic                    out_overflow
);

  state_t                  state;
  state_t                  state_next;
  logic                    beat_accept;
  logic                    out_fire;
  logic                    first_beat;
  logic                    sticky_ovf;
  logic signed [WIDTH-1:0] acc;
  logic signed [WIDTH:0]   acc_sum;
  sat_t                    acc_sat;

  // Last-beat marker travelling alongside the multiplier pipeline.
  logic                    last_d1;
  logic                    last_d2;
  logic                    acc_last;

  logic                    mul_valid;
  logic signed [WIDTH-1:0] mul_r;
  logic                    mul_ovf;

  assign beat_accept = in_valid && in_ready;
  assign out_fire    = out_valid && out_ready;

  fixed_point_mul u_mul (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (beat_accept),
    .in_a         (in_x),
    .in_b         (in_w),
    .out_valid    (mul_valid),
    .out_r        (mul_r),
    .out_overflow (mul_ovf)
  );

  // Accumulate at WIDTH+1 bits so the true sum is visible before clamping.
  assign acc_sum = {acc[WIDTH-1], acc} + {mul_r[WIDTH-1], mul_r};
  assign acc_sat = saturate({{(WIDTH-1){acc_sum[WIDTH]}}, acc_sum});

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_ACCUM;
    else     state <= state_next;
  end

  // FSM next-state and handshake outputs.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned and infers a latch.
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      ST_ACCUM: begin
        in_ready = !rst;
        if (beat_accept && in_last) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (acc_last) state_next = ST_HOLD;
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_next = ST_ACCUM;
      end
      default: state_next = ST_ACCUM;
    endcase
  end

  // Track the last beat through the two multiplier stages and the accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_d1  <= 1'b0;
      last_d2  <= 1'b0;
      acc_last <= 1'b0;
    end else begin
      last_d1  <= beat_accept && in_last;
      last_d2  <= last_d1;
      acc_last <= mul_valid && last_d2;
    end
  end

  // First-beat flag: armed after reset and after each result handshake.
  always_ff @(posedge clk) begin
    if (rst)              first_beat <= 1'b1;
    else if (out_fire)    first_beat <= 1'b1;
    else if (beat_accept) first_beat <= 1'b0;
  end

  // Accumulator and sticky overflow: seeded with bias on the first beat, then
  // each rounded product is added with saturation.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      sticky_ovf <= 1'b0;
    end else if (beat_accept && first_beat) begin
      acc        <= bias;
      sticky_ovf <= 1'b0;
    end else if (mul_valid) begin
      acc        <= acc_sat.value;
      sticky_ovf <= sticky_ovf | mul_ovf | acc_sat.ovf;
    end
  end

  assign out_y        = acc;
  assign out_overflow = sticky_ovf;

endmodule

// File: tb/tb_fixed_point_dot_accum.sv
// Self-checking bench for fixed_point_dot_accum: directed vector table,
// hand-written backpressure and reset sequences, and randomized vectors
// checked against a plain-arithmetic reference model.
module tb_fixed_point_dot_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_x;
  logic [31:0] in_w;
  logic        in_last;
  logic [31:0] bias;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_y;
  logic        out_overflow;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  fixed_point_dot_accum dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_x         (in_x),
    .in_w         (in_w),
    .in_last      (in_last),
    .bias         (bias),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_y        (out_y),
    .out_overflow (out_overflow)
  );

  typedef struct packed {
    int                n;
    logic [3:0][31:0]  xs;
    logic [3:0][31:0]  ws;
    logic [31:0]       b;
    logic [31:0]       exp_y;
    logic              exp_ovf;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_total++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  function automatic vec_t mk(input int n, input logic [31:0] x0, input logic [31:0] w0,
                              input logic [31:0] x1, input logic [31:0] w1,
                              input logic [31:0] b, input logic [31:0] ey, input logic eo);
    vec_t v;
    v.n       = n;
    v.xs      = {32'h0, 32'h0, x1, x0};
    v.ws      = {32'h0, 32'h0, w1, w0};
    v.b       = b;
    v.exp_y   = ey;
    v.exp_ovf = eo;
    return v;
  endfunction

  // Reference: exact products, round half-up, clamp, then clamped running sum.
  function automatic void model(input int n, input logic [3:0][31:0] xs, input logic [3:0][31:0] ws,
                                input logic [31:0] b, output logic [31:0] y, output logic ovf);
    longint acc;
    longint p;
    longint r;
    acc = longint'(int'(b));
    ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      p = longint'(int'(xs[i])) * longint'(int'(ws[i]));
      r = (p + 64'sd32768) >>> 16;
      if (r > 64'sd2147483647)       begin r = 64'sd2147483647;  ovf = 1'b1; end
      else if (r < -64'sd2147483648) begin r = -64'sd2147483648; ovf = 1'b1; end
      acc = acc + r;
      if (acc > 64'sd2147483647)       begin acc = 64'sd2147483647;  ovf = 1'b1; end
      else if (acc < -64'sd2147483648) begin acc = -64'sd2147483648; ovf = 1'b1; end
    end
    y = acc[31:0];
  endfunction

  // Present one beat and hold it until the edge that accepts it.
  task automatic wait_accept();
    int budget = 0;
    while (!in_ready && budget < 20) begin
      @(posedge clk); #1;
      budget++;
    end
    check("in_ready_for_beat", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic send_vec(input int n, input logic [3:0][31:0] xs, input logic [3:0][31:0] ws,
                          input logic [31:0] b, input bit bubbles);
    for (int i = 0; i < n; i++) begin
      if (bubbles && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        in_x     = $urandom;
        in_w     = $urandom;
        in_last  = 1'b1;
        bias     = $urandom;
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
      in_valid = 1'b1;
      in_x     = xs[i];
      in_w     = ws[i];
      in_last  = (i == n - 1);
      bias     = (i == 0) ? b : $urandom;
      wait_accept();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Wait for the result (starting right after the last-beat edge), check it,
  // then complete the handshake.
  task automatic drain(input string tag, input logic [31:0] ey, input logic eo, input bit chk_lat);
    int lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_out_valid"}, {31'b0, out_valid}, 32'd1);
    if (chk_lat) check({tag, "_latency"}, lat, 32'd3);
    check({tag, "_y"}, out_y, ey);
    check({tag, "_ovf"}, {31'b0, out_overflow}, {31'b0, eo});
    check({tag, "_in_ready_hold"}, {31'b0, in_ready}, 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_out_valid_after"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_in_ready_after"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [3:0][31:0] xs;
    logic [3:0][31:0] ws;
    logic [31:0]      b;
    logic [31:0]      ey;
    logic             eo;
    bit               saw_valid;
    int               n;

    tbl[0] = mk(1, 32'h0002_0000, 32'h0003_0000, 0, 0, 32'h0, 32'h0006_0000, 1'b0);
    tbl[1] = mk(2, 32'h0002_0000, 32'h0001_8000, 32'h0003_0000, 32'hFFFF_8000,
                32'h0000_4000, 32'h0001_C000, 1'b0);
    tbl[2] = mk(1, 32'h0000_0001, 32'h0000_8000, 0, 0, 32'h0, 32'h0000_0001, 1'b0);
    tbl[3] = mk(1, 32'hFFFF_FFFF, 32'h0000_8000, 0, 0, 32'h0, 32'h0000_0000, 1'b0);
    tbl[4] = mk(1, 32'h7FFF_0000, 32'h0002_0000, 0, 0, 32'h0, 32'h7FFF_FFFF, 1'b1);
    tbl[5] = mk(1, 32'h0001_0000, 32'h0001_0000, 0, 0, 32'h0, 32'h0001_0000, 1'b0);
    tbl[6] = mk(2, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000,
                32'h7FFF_0000, 32'h7FFF_FFFF, 1'b1);

    rst = 1'b1; in_valid = 1'b0; in_x = '0; in_w = '0; in_last = 1'b0;
    bias = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_y", out_y, 32'd0);
    check("rst_out_ovf", {31'b0, out_overflow}, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Directed vectors from the table.
    for (int t = 0; t < 7; t++) begin
      send_vec(tbl[t].n, tbl[t].xs, tbl[t].ws, tbl[t].b, 1'b0);
      drain($sformatf("tbl%0d", t), tbl[t].exp_y, tbl[t].exp_ovf, 1'b1);
    end

    // Backpressure: result held for 5 cycles, next vector waits for handshake.
    xs = {96'h0, 32'h0001_0000};
    ws = {96'h0, 32'h0002_8000};
    send_vec(1, xs, ws, 32'h0000_1000, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp_valid_%0d", c), {31'b0, out_valid}, 32'd1);
      check($sformatf("bp_y_%0d", c), out_y, 32'h0002_9000);
      check($sformatf("bp_in_ready_%0d", c), {31'b0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b1; in_x = 32'h0002_0000; in_w = 32'h0002_0000; in_last = 1'b1;
    bias = 32'h0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_handshake_valid", {31'b0, out_valid}, 32'd0);
    check("bp_ready_after_hs", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    check("bp_next_accepted", {31'b0, in_ready}, 32'd0);
    drain("bp_next", 32'h0004_0000, 1'b0, 1'b1);

    // Randomized vectors with optional bubbles against the reference model.
    for (int v = 0; v < 40; v++) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 7) == 0) begin
          xs[i] = $urandom;
          ws[i] = $urandom;
        end else begin
          xs[i] = $urandom_range(0, 32'h0008_0000) - 32'h0004_0000;
          ws[i] = $urandom_range(0, 32'h0008_0000) - 32'h0004_0000;
        end
      end
      b = ($urandom_range(0, 5) == 0) ? $urandom
                                      : $urandom_range(0, 32'h0010_0000) - 32'h0008_0000;
      model(n, xs, ws, b, ey, eo);
      send_vec(n, xs, ws, b, v[0]);
      drain($sformatf("rnd%0d", v), ey, eo, 1'b1);
    end

    // Reset mid-vector: partial beats are discarded and no result emerges.
    in_valid = 1'b1; in_x = 32'h7FFF_0000; in_w = 32'h7FFF_0000; in_last = 1'b0;
    bias = 32'h1234_0000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("mid_rst_out_y", out_y, 32'd0);
    check("mid_rst_ovf", {31'b0, out_overflow}, 32'd0);
    rst = 1'b0;
    saw_valid = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) saw_valid = 1'b1;
    end
    check("mid_rst_no_partial", {31'b0, saw_valid}, 32'd0);
    xs = {96'h0, 32'h0001_0000};
    ws = {96'h0, 32'h0001_0000};
    send_vec(1, xs, ws, 32'h0, 1'b0);
    drain("post_rst_vec", 32'h0001_0000, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
